dmux: RTL and testbench

// - 1-to-2 demultiplexer for the Hack CPU datapath: steers `in` to output `a` (sel=0) or `b` (sel=1).
// - The unselected output is driven to zero.
// - The primary outputs a/b are purely combinational, so they are usable inside the single-cycle
//   CPU path without a clock edge.
// - Registered copies and optional routing statistics serve pipelined consumers and debug.
//

---
 rtl/dmux.sv | 59 +++++
 tb/tb_dmux.sv | 136 +++++++++++++
 2 files changed

// File: rtl/dmux.sv
// 1-to-2 demultiplexer with combinational outputs, registered copies and
// optional saturating routing counters (enabled by defining DMUX_STATS_EN).
module dmux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             sel,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  // The ternary merges both arms bitwise when sel is unknown, so an X on sel
  // yields X wherever in is 1 instead of silently picking one output.
  assign a = sel ? '0 : in;
  assign b = sel ? in : '0;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a;
      b_q <= b;
    end
  end

`ifdef DMUX_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic hit_a;
  logic hit_b;

  assign hit_a = |a;
  assign hit_b = |b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (hit_a && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + 1'b1;
      if (hit_b && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + 1'b1;
    end
  end
`else
  assign cnt_a = '0;
  assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_dmux.sv
// Randomized self-checking bench for dmux against a behavioural routing model;
// counter expectations follow whether DMUX_STATS_EN is defined.
module tb_dmux;

  localparam int WIDTH = 8;
  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef DMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             sel = 1'b0;
  logic [WIDTH-1:0] a, b, a_q, b_q;
  logic [CNT_W-1:0] cnt_a, cnt_b;

  int total = 0;
  int bad = 0;

  // Reference state: expected registered outputs and event counts.
  int exp_aq = 0, exp_bq = 0, exp_ca = 0, exp_cb = 0;

  dmux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in(din), .sel(sel),
    .a(a), .b(b), .a_q(a_q), .b_q(b_q), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_comb(input logic [WIDTH-1:0] i, input logic s);
    check("a", 32'(a), s ? 32'd0 : 32'(i));
    check("b", 32'(b), s ? 32'(i) : 32'd0);
  endtask

  task automatic check_regs();
    check("a_q", 32'(a_q), exp_aq);
    check("b_q", 32'(b_q), exp_bq);
    check("cnt_a", 32'(cnt_a), exp_ca);
    check("cnt_b", 32'(cnt_b), exp_cb);
  endtask

  // Called #1 after a posedge: apply inputs, check comb, clock, check regs.
  task automatic step(input logic [WIDTH-1:0] i, input logic s);
    din = i;
    sel = s;
    #1;
    check_comb(i, s);
    @(posedge clk);
    exp_aq = s ? 0 : int'(i);
    exp_bq = s ? int'(i) : 0;
    if (STATS) begin
      if (i != 0 && !s) exp_ca = (exp_ca < CNT_MAX) ? exp_ca + 1 : CNT_MAX;
      if (i != 0 &&  s) exp_cb = (exp_cb < CNT_MAX) ? exp_cb + 1 : CNT_MAX;
    end
    #1;
    check_regs();
  endtask

  // Asserts reset between edges, checks the immediate clear and that a/b
  // keep working, then releases mid-cycle with zero inputs.
  task automatic pulse_reset();
    logic [WIDTH-1:0] r;
    logic s;
    #2;
    rst_n = 1'b0;
    #1;
    exp_aq = 0; exp_bq = 0; exp_ca = 0; exp_cb = 0;
    check_regs();
    for (int k = 0; k < 3; k++) begin
      r = WIDTH'($urandom);
      s = 1'($urandom);
      din = r;
      sel = s;
      #7;
      check_comb(r, s);
      check_regs();
    end
    din = '0;
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    // Combinational path with reset held.
    din = 8'h01; sel = 1'b0; #10; check_comb(8'h01, 1'b0);
    din = 8'h01; sel = 1'b1; #10; check_comb(8'h01, 1'b1);
    din = 8'h00; sel = 1'b0; #10; check_comb(8'h00, 1'b0);
    check_regs();

    pulse_reset();

    for (int k = 0; k < 3; k++) step(8'h01, 1'b0);
    for (int k = 0; k < 2; k++) step(8'h01, 1'b1);

    // Drive past saturation of cnt_a (and then cnt_b).
    for (int k = 0; k < 10; k++) step(8'hA5, 1'b0);
    for (int k = 0; k < 10; k++) step(8'h3C, 1'b1);
    step(8'h00, 1'b0);
    step(8'hFF, 1'b1);

    pulse_reset();
    step(8'h80, 1'b0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 39) == 0) pulse_reset();
      else if ($urandom_range(0, 3) == 0) step('0, 1'($urandom));
      else step(WIDTH'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
